// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and encodings for the MEM-stage data access controller.
package mem_access_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DONE,
      S_CANCEL
   } state_e;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // MemReadType bit selecting zero- (1) or sign- (0) extension
   localparam int RT_ZEXT_BIT = 2;

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      return ((size == SZ_HALF) && addr_lo[0]) ||
             ((size == SZ_WORD) && (addr_lo != 2'b00));
   endfunction

endpackage

// File: rtl/mem_access_ctrl_lane_align.sv
// Byte-lane steering: store strobes/replication and load extraction/extension.
module mem_access_ctrl_lane_align
   import mem_access_ctrl_pkg::*;
(
   input  logic [1:0]  st_size,
   input  logic [1:0]  st_addr_lo,
   input  logic [31:0] st_data,
   input  logic [1:0]  ld_size,
   input  logic [1:0]  ld_addr_lo,
   input  logic        ld_zext,
   input  logic [31:0] rdata,
   output logic [3:0]  st_wstrb,
   output logic [31:0] st_wdata,
   output logic [31:0] ld_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      st_wstrb = 4'b1111;
      st_wdata = st_data;
      case (st_size)
         SZ_BYTE: begin
            st_wstrb = 4'b0001 << st_addr_lo;
            st_wdata = {4{st_data[7:0]}};
         end
         SZ_HALF: begin
            st_wstrb = st_addr_lo[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{st_data[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      case (ld_addr_lo)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];
      case (ld_size)
         SZ_BYTE: ld_data = {{24{~ld_zext & byte_sel[7]}}, byte_sel};
         SZ_HALF: ld_data = {{16{~ld_zext & half_sel[15]}}, half_sel};
         default: ld_data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data access sequencer: one outstanding SRAM-like bus transaction,
// pipeline stall while it is in flight, aligned load result for write-back.
//
// state  | meaning
// IDLE   | no transaction; a new aligned access is latched and requested
// REQ    | data_req high, waiting for data_addr_ok
// WAIT   | address accepted, waiting for data_data_ok
// DONE   | result held until the pipeline advances or flushes
// CANCEL | killed after address acceptance; drain data_data_ok, drop data
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter bit CHECK_ALIGN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_valid_i,
   input  logic              MemReadM,
   input  logic              MemWriteM,
   input  logic [2:0]        MemReadType,
   input  logic [31:0]       ALUout,
   input  logic [31:0]       store_data_i,
   input  logic              flush_i,
   input  logic              advance_i,
   output logic              stall_o,
   output logic [31:0]       load_data_o,
   output logic              load_valid_o,
   output logic              adel_o,
   output logic              ades_o,
   output logic              data_req,
   output logic              data_wr,
   output logic [1:0]        data_size,
   output logic [ADDR_W-1:0] data_addr,
   output logic [3:0]        data_wstrb,
   output logic [31:0]       data_wdata,
   input  logic              data_addr_ok,
   input  logic              data_data_ok,
   input  logic [31:0]       data_rdata
);

   state_e              state_q, state_d;
   logic                wr_q, wr_d;
   logic [1:0]          size_q, size_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [3:0]          wstrb_q, wstrb_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                zext_q, zext_d;
   logic [31:0]         ldata_q, ldata_d;

   logic                mem_op, misaligned, access;
   logic [3:0]          st_wstrb;
   logic [31:0]         st_wdata, ld_data;

   assign mem_op     = mem_valid_i & (MemReadM | MemWriteM);
   assign misaligned = CHECK_ALIGN && is_misaligned(MemReadType[1:0], ALUout[1:0]);
   assign access     = mem_op & ~flush_i & ~misaligned;
   assign adel_o     = mem_op & MemReadM & misaligned;
   assign ades_o     = mem_op & MemWriteM & misaligned;

   mem_access_ctrl_lane_align u_lane_align (
      .st_size    (MemReadType[1:0]),
      .st_addr_lo (ALUout[1:0]),
      .st_data    (store_data_i),
      .ld_size    (size_q),
      .ld_addr_lo (addr_q[1:0]),
      .ld_zext    (zext_q),
      .rdata      (data_rdata),
      .st_wstrb   (st_wstrb),
      .st_wdata   (st_wdata),
      .ld_data    (ld_data)
   );

   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      size_d  = size_q;
      addr_d  = addr_q;
      wstrb_d = wstrb_q;
      wdata_d = wdata_q;
      zext_d  = zext_q;
      ldata_d = ldata_q;
      case (state_q)
         S_IDLE: begin
            if (access) begin
               state_d = S_REQ;
               wr_d    = MemWriteM;
               size_d  = MemReadType[1:0];
               addr_d  = ADDR_W'(ALUout);
               wstrb_d = MemWriteM ? st_wstrb : 4'b0000;
               wdata_d = st_wdata;
               zext_d  = MemReadType[RT_ZEXT_BIT];
            end
         end
         S_REQ: begin
            if (flush_i)          state_d = data_addr_ok ? S_CANCEL : S_IDLE;
            else if (data_addr_ok) state_d = S_WAIT;
         end
         S_WAIT: begin
            // a flush arriving with data_ok consumes the data and skips DONE
            if (data_data_ok) begin
               state_d = flush_i ? S_IDLE : S_DONE;
               if (!wr_q && !flush_i) ldata_d = ld_data;
            end else if (flush_i) begin
               state_d = S_CANCEL;
            end
         end
         S_DONE: begin
            if (advance_i || flush_i) state_d = S_IDLE;
         end
         S_CANCEL: begin
            if (data_data_ok) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         wr_q    <= 1'b0;
         size_q  <= 2'b00;
         addr_q  <= '0;
         wstrb_q <= 4'b0000;
         wdata_q <= 32'h0;
         zext_q  <= 1'b0;
         ldata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         size_q  <= size_d;
         addr_q  <= addr_d;
         wstrb_q <= wstrb_d;
         wdata_q <= wdata_d;
         zext_q  <= zext_d;
         ldata_q <= ldata_d;
      end
   end

   assign data_req     = (state_q == S_REQ);
   assign data_wr      = wr_q;
   assign data_size    = size_q;
   assign data_addr    = addr_q;
   assign data_wstrb   = wstrb_q;
   assign data_wdata   = wdata_q;
   assign load_data_o  = ldata_q;
   assign load_valid_o = (state_q == S_DONE) && !wr_q;
   assign stall_o      = (state_q == S_IDLE) ? access : (state_q != S_DONE);

endmodule
